// File: rtl/router_pkg.sv
// Shared definitions for the router read-side engine.
//   - Byte and header field geometry (length in header[7:2], address in header[1:0]).
//   - Fetch FSM state encoding.
//   - Skid buffer entry layout {sop, eop, data}.
//   - Default stall timeout.
package router_pkg;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned LEN_W       = 6;
   localparam int unsigned LEN_MSB     = 7;
   localparam int unsigned LEN_LSB     = 2;
   localparam int unsigned ADDR_W      = 2;
   localparam int unsigned TIMEOUT_DEF = 30;

   typedef enum logic [1:0] {
      StIdle,
      StHdrWait,
      StBody
   } rd_state_e;

   typedef struct packed {
      logic              sop;
      logic              eop;
      logic [DATA_W-1:0] data;
   } skid_entry_t;

endpackage

// File: rtl/router_rd_skid.sv
// Two-entry valid/ready skid buffer carrying tagged packet bytes in FIFO order.
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   flush_i       synchronous discard of all entries (push ignored that cycle)
//   push_i        write push_data_i (caller guarantees space)
//   ready_i       downstream accept; pop when valid_o && ready_i
//   valid_o       head entry present
//   head_o        head entry, zero when empty
//   cnt_o         occupancy (0..2)
module router_rd_skid
   import router_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        flush_i,
   input  logic        push_i,
   input  skid_entry_t push_data_i,
   input  logic        ready_i,
   output logic        valid_o,
   output skid_entry_t head_o,
   output logic [1:0]  cnt_o
);

   skid_entry_t mem_q [2];
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        pop, push_ok;

   assign valid_o = (cnt_q != 2'd0);
   assign pop     = valid_o && ready_i;
   // A push into a full buffer is only possible alongside a pop.
   assign push_ok = push_i && ((cnt_q != 2'd2) || pop);
   assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
   assign cnt_o   = cnt_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         cnt_d    = 2'd0;
      end else begin
         if (push_ok) wr_ptr_d = ~wr_ptr_q;
         if (pop)     rd_ptr_d = ~rd_ptr_q;
         cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/router_pkt_reader.sv
// Read-side engine for one router output port. Fetches header, payload and parity bytes
// from the port FIFO (1-cycle read latency), forwards them through a 2-entry skid buffer,
// checks packet parity and pulses a FIFO soft reset after a long downstream stall.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   fifo_empty/fifo_data FIFO status and read data
//   fifo_rd_en           FIFO read enable
//   valid_out/data_out   head byte of the skid buffer; read_in accepts it
//   sop/eop              head byte is header / parity byte
//   pkt_done/parity_err  pulse when the parity byte returns; error on mismatch
//   soft_rst_out         1-cycle stall timeout pulse to the FIFO
// Optional: define ROUTER_RD_STATS_EN to add pkt_cnt (wrapping) and err_cnt (saturating).
module router_pkt_reader
   import router_pkg::*;
#(
   parameter int unsigned DATA_W  = router_pkg::DATA_W,
   parameter int unsigned LEN_W   = router_pkg::LEN_W,
   parameter int unsigned TIMEOUT = router_pkg::TIMEOUT_DEF,
   parameter int unsigned TO_W    = 5
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd_en,
   output logic              valid_out,
   output logic [DATA_W-1:0] data_out,
   input  logic              read_in,
   output logic              sop,
   output logic              eop,
   output logic              pkt_done,
   output logic              parity_err,
`ifdef ROUTER_RD_STATS_EN
   output logic [15:0]       pkt_cnt,
   output logic [7:0]        err_cnt,
`endif
   output logic              soft_rst_out
);

   localparam int unsigned RemW = LEN_W + 1;

   rd_state_e         state_q, state_d;
   logic [RemW-1:0]   rem_q, rem_d;
   logic [RemW-1:0]   ret_rem_q, ret_rem_d;
   logic [DATA_W-1:0] xor_q, xor_d;
   logic              pend_q, pend_d;
   logic              pend_hdr_q, pend_hdr_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              soft_rst_q, soft_rst_d;
   logic              run_q;

   logic [1:0]        buf_cnt;
   logic [2:0]        occ;
   logic              pop, rd_ok, stall, push;
   logic [RemW-1:0]   hdr_rem;
   skid_entry_t       push_entry, head;

   assign pop     = valid_out && read_in;
   assign stall   = valid_out && !read_in;
   // Bytes buffered plus the one in flight, after this cycle's pop.
   assign occ     = {1'b0, buf_cnt} + {2'b0, pend_q} - {2'b0, pop};
   // run_q keeps fifo_rd_en low while rstn is asserted.
   assign rd_ok   = run_q && !soft_rst_q && !fifo_empty && (occ < 3'd2);
   assign hdr_rem = RemW'(fifo_data[LEN_MSB:LEN_LSB]) + RemW'(1);

   // Fetch FSM: one header read, then len+1 body reads (payload + parity).
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      fifo_rd_en = 1'b0;
      pend_hdr_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rd_ok) begin
               fifo_rd_en = 1'b1;
               pend_hdr_d = 1'b1;
               state_d    = StHdrWait;
            end
         end
         StHdrWait: begin
            if (pend_q) begin
               rem_d   = hdr_rem;
               state_d = StBody;
            end
         end
         StBody: begin
            if (rd_ok) begin
               fifo_rd_en = 1'b1;
               rem_d      = rem_q - RemW'(1);
               if (rem_q == RemW'(1)) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (soft_rst_q) begin
         state_d = StIdle;
         rem_d   = '0;
      end
      pend_d = fifo_rd_en;
   end

   // Return path: tag and push returned bytes, track parity.
   always_comb begin
      push       = 1'b0;
      push_entry = '0;
      ret_rem_d  = ret_rem_q;
      xor_d      = xor_q;
      pkt_done   = 1'b0;
      parity_err = 1'b0;
      if (pend_q && !soft_rst_q) begin
         push            = 1'b1;
         push_entry.data = fifo_data;
         if (pend_hdr_q) begin
            push_entry.sop = 1'b1;
            ret_rem_d      = hdr_rem;
            xor_d          = fifo_data;
         end else begin
            ret_rem_d = ret_rem_q - RemW'(1);
            if (ret_rem_q == RemW'(1)) begin
               push_entry.eop = 1'b1;
               pkt_done       = 1'b1;
               parity_err     = (xor_q != fifo_data);
            end else begin
               xor_d = xor_q ^ fifo_data;
            end
         end
      end
      if (soft_rst_q) begin
         ret_rem_d = '0;
         xor_d     = '0;
      end
   end

   // Stall timeout: counts consecutive stalled cycles, cleared by a pop or an empty head.
   always_comb begin
      to_cnt_d   = '0;
      soft_rst_d = 1'b0;
      if (!soft_rst_q && stall) begin
         if (to_cnt_q == TO_W'(TIMEOUT - 1)) soft_rst_d = 1'b1;
         else                                to_cnt_d   = to_cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         rem_q      <= '0;
         ret_rem_q  <= '0;
         xor_q      <= '0;
         pend_q     <= 1'b0;
         pend_hdr_q <= 1'b0;
         to_cnt_q   <= '0;
         soft_rst_q <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         ret_rem_q  <= ret_rem_d;
         xor_q      <= xor_d;
         pend_q     <= pend_d;
         pend_hdr_q <= pend_hdr_d;
         to_cnt_q   <= to_cnt_d;
         soft_rst_q <= soft_rst_d;
         run_q      <= 1'b1;
      end
   end

   router_rd_skid u_skid (
      .clk         (clk),
      .rstn        (rstn),
      .flush_i     (soft_rst_q),
      .push_i      (push),
      .push_data_i (push_entry),
      .ready_i     (read_in),
      .valid_o     (valid_out),
      .head_o      (head),
      .cnt_o       (buf_cnt)
   );

   assign data_out     = head.data;
   assign sop          = head.sop;
   assign eop          = head.eop;
   assign soft_rst_out = soft_rst_q;

`ifdef ROUTER_RD_STATS_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      err_cnt_d = err_cnt_q;
      if (pkt_done) pkt_cnt_d = pkt_cnt_q + 16'd1;
      if ((parity_err || soft_rst_q) && (err_cnt_q != 8'hff)) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign pkt_cnt = pkt_cnt_q;
   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_router_pkt_reader.sv
// Bench for router_pkt_reader: a queue-based FIFO model with 1-cycle read latency feeds the
// DUT; expected output streams are built per packet (header, payload, XOR parity byte).
module tb_router_pkt_reader;

   localparam int unsigned TIMEOUT = 30;

   logic       clk = 1'b0;
   logic       rstn;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_rd_en;
   logic       valid_out;
   logic [7:0] data_out;
   logic       read_in;
   logic       sop, eop, pkt_done, parity_err, soft_rst_out;
`ifdef ROUTER_RD_STATS_EN
   logic [15:0] pkt_cnt;
   logic [7:0]  err_cnt;
`endif

   always #5 clk = ~clk;

   router_pkt_reader #(
      .DATA_W  (8),
      .LEN_W   (6),
      .TIMEOUT (TIMEOUT),
      .TO_W    (5)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .fifo_empty   (fifo_empty),
      .fifo_data    (fifo_data),
      .fifo_rd_en   (fifo_rd_en),
      .valid_out    (valid_out),
      .data_out     (data_out),
      .read_in      (read_in),
      .sop          (sop),
      .eop          (eop),
      .pkt_done     (pkt_done),
      .parity_err   (parity_err),
`ifdef ROUTER_RD_STATS_EN
      .pkt_cnt      (pkt_cnt),
      .err_cnt      (err_cnt),
`endif
      .soft_rst_out (soft_rst_out)
   );

   int errors = 0;
   int checks = 0;

   // FIFO model and scoreboard state.
   logic [7:0] fifo_q[$];
   logic [7:0] nxt_data = 8'h00;
   logic [9:0] obs_q[$];
   logic [9:0] exp_q[$];
   int         obs_cyc_q[$];
   int         cyc = 0;
   int         occ = 0;
   int         n_done, n_perr, n_soft;
   int         viol_occ, viol_empty, viol_hold, soft_bad, after_soft_bad;
   int         stall_run = 0;
   bit         prev_stall = 1'b0, prev_soft = 1'b0;
   logic [7:0] prev_data = 8'h00;
   int         exp_pkt_total = 0, exp_err_total = 0;

   task automatic clear_sb();
      obs_q.delete();
      exp_q.delete();
      obs_cyc_q.delete();
      n_done = 0; n_perr = 0; n_soft = 0;
      viol_occ = 0; viol_empty = 0; viol_hold = 0; soft_bad = 0; after_soft_bad = 0;
   endtask

   // Append a packet to the FIFO and its expected output to the model stream.
   task automatic add_pkt(input logic [7:0] hdr, input bit bad);
      logic [7:0] x, b;
      int         len;
      len = int'(hdr[7:2]);
      fifo_q.push_back(hdr);
      exp_q.push_back({2'b10, hdr});
      x = hdr;
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom);
         x = x ^ b;
         fifo_q.push_back(b);
         exp_q.push_back({2'b00, b});
      end
      if (bad) x = x ^ 8'h01;
      fifo_q.push_back(x);
      exp_q.push_back({2'b01, x});
   endtask

   function automatic logic [7:0] rand_hdr(input int max_len);
      logic [5:0] l6;
      logic [1:0] a2;
      l6 = 6'($urandom_range(0, max_len));
      a2 = 2'($urandom_range(0, 3));
      return {l6, a2};
   endfunction

   function automatic int first_diff();
      int n;
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   // One clock cycle: drive inputs and observe outputs mid-cycle.
   task automatic step(input bit rin);
      bit stall;
      @(negedge clk);
      fifo_data  = nxt_data;
      read_in    = rin;
      fifo_empty = (fifo_q.size() == 0);
      #1;
      cyc++;
      if (prev_stall && !prev_soft && (data_out !== prev_data)) viol_hold++;
      if (prev_soft && (valid_out !== 1'b0)) after_soft_bad++;
      if (valid_out && read_in) begin
         obs_q.push_back({sop, eop, data_out});
         obs_cyc_q.push_back(cyc);
         occ--;
      end
      if (pkt_done) n_done++;
      if (parity_err) n_perr++;
      if (soft_rst_out) begin
         n_soft++;
         if (stall_run != TIMEOUT) soft_bad++;
         if (fifo_rd_en) soft_bad++;
      end
      if (fifo_rd_en) begin
         if (fifo_q.size() == 0) viol_empty++;
         else nxt_data = fifo_q.pop_front();
         occ++;
         if (occ > 2) viol_occ++;
      end
      stall      = valid_out && !read_in;
      stall_run  = stall ? stall_run + 1 : 0;
      prev_stall = stall;
      prev_data  = data_out;
      prev_soft  = soft_rst_out;
      if (soft_rst_out) begin
         fifo_q.delete();
         occ = 0;
      end
   endtask

   // mode 0: read_in held high, 1: toggling, 2: random with mostly-high ready.
   task automatic run(input int budget, input int mode);
      bit rin;
      for (int i = 0; i < budget; i++) begin
         if (obs_q.size() >= exp_q.size() && fifo_q.size() == 0) break;
         case (mode)
            0:       rin = 1'b1;
            1:       rin = (i % 2 == 0);
            default: rin = ($urandom_range(0, 3) != 0);
         endcase
         step(rin);
      end
      step(1'b1);
      step(1'b1);
   endtask

   task automatic test_reset();
      rstn       = 1'b0;
      fifo_empty = 1'b0;
      fifo_data  = 8'hA5;
      read_in    = 1'b1;
      #1;
      checks++;
      if ({fifo_rd_en, valid_out, data_out, sop, eop, pkt_done, parity_err, soft_rst_out}
          !== 15'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %b required 0",
                  {fifo_rd_en, valid_out, data_out, sop, eop, pkt_done, parity_err, soft_rst_out});
      end
`ifdef ROUTER_RD_STATS_EN
      checks++;
      if ({pkt_cnt, err_cnt} !== 24'h0) begin
         errors++;
         $display("FAIL reset_stats: got %h/%h required 0/0", pkt_cnt, err_cnt);
      end
`endif
      fifo_empty = 1'b1;
      read_in    = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      step(1'b0);
   endtask

   task automatic test_single_pkt();
      int d;
      clear_sb();
      add_pkt(8'h39, 1'b0);
      run(100, 0);
      exp_pkt_total += 1;
      checks++;
      if (obs_q.size() != 16) begin
         errors++;
         $display("FAIL single_count: got %0d bytes required 16", obs_q.size());
      end
      d = first_diff();
      checks++;
      if (d != -1) begin
         errors++;
         $display("FAIL single_data: idx %0d got %h required %h", d, obs_q[d], exp_q[d]);
      end
      checks++;
      if (n_done != 1 || n_perr != 0) begin
         errors++;
         $display("FAIL single_done: got done=%0d perr=%0d required 1/0", n_done, n_perr);
      end
      if (obs_cyc_q.size() == 16) begin
         checks++;
         if (obs_cyc_q[15] - obs_cyc_q[1] != 14) begin
            errors++;
            $display("FAIL single_rate: got %0d cycles required 14",
                     obs_cyc_q[15] - obs_cyc_q[1]);
         end
      end
   endtask

   task automatic test_parity_err();
      int d;
      clear_sb();
      add_pkt(8'h39, 1'b1);
      run(100, 0);
      exp_pkt_total += 1;
      exp_err_total += 1;
      d = first_diff();
      checks++;
      if (d != -1 || obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL perr_data: got %0d bytes diff at %0d required %0d bytes no diff",
                  obs_q.size(), d, exp_q.size());
      end
      checks++;
      if (n_done != 1 || n_perr != 1) begin
         errors++;
         $display("FAIL perr_pulses: got done=%0d perr=%0d required 1/1", n_done, n_perr);
      end
   endtask

   task automatic test_len0_back_to_back();
      int d;
      clear_sb();
      add_pkt(8'h02, 1'b0);
      run(50, 0);
      checks++;
      if (obs_q.size() != 2 || first_diff() != -1 || n_done != 1 || n_perr != 0) begin
         errors++;
         $display("FAIL len0_single: got bytes=%0d done=%0d perr=%0d required 2/1/0",
                  obs_q.size(), n_done, n_perr);
      end
      clear_sb();
      add_pkt(8'h02, 1'b0);
      add_pkt(8'h02, 1'b0);
      run(50, 0);
      exp_pkt_total += 3;
      d = first_diff();
      checks++;
      if (obs_q.size() != 4 || d != -1) begin
         errors++;
         $display("FAIL len0_b2b_data: got %0d bytes diff at %0d required 4 no diff",
                  obs_q.size(), d);
      end
      checks++;
      if (n_done != 2 || n_perr != 0) begin
         errors++;
         $display("FAIL len0_b2b_done: got done=%0d perr=%0d required 2/0", n_done, n_perr);
      end
   endtask

   task automatic test_toggle();
      int d;
      clear_sb();
      add_pkt(rand_hdr(20), 1'b0);
      add_pkt(rand_hdr(20), 1'b1);
      add_pkt(rand_hdr(20), 1'b0);
      run(500, 1);
      exp_pkt_total += 3;
      exp_err_total += 1;
      d = first_diff();
      checks++;
      if (obs_q.size() != exp_q.size() || d != -1) begin
         errors++;
         $display("FAIL toggle_data: got %0d bytes diff at %0d required %0d no diff",
                  obs_q.size(), d, exp_q.size());
      end
      checks++;
      if (n_done != 3 || n_perr != 1) begin
         errors++;
         $display("FAIL toggle_done: got done=%0d perr=%0d required 3/1", n_done, n_perr);
      end
      checks++;
      if (viol_hold != 0) begin
         errors++;
         $display("FAIL toggle_hold: got %0d changes while stalled required 0", viol_hold);
      end
      checks++;
      if (viol_occ != 0 || viol_empty != 0) begin
         errors++;
         $display("FAIL toggle_read_rule: got occ=%0d empty=%0d violations required 0/0",
                  viol_occ, viol_empty);
      end
   endtask

   task automatic test_random_ready();
      int d, nbad;
      clear_sb();
      nbad = 0;
      for (int p = 0; p < 4; p++) begin
         bit bad;
         bad = ($urandom_range(0, 1) == 1);
         if (bad) nbad++;
         add_pkt(rand_hdr(63), bad);
      end
      run(2000, 2);
      exp_pkt_total += 4;
      exp_err_total += nbad;
      d = first_diff();
      checks++;
      if (obs_q.size() != exp_q.size() || d != -1) begin
         errors++;
         $display("FAIL random_data: got %0d bytes diff at %0d required %0d no diff",
                  obs_q.size(), d, exp_q.size());
      end
      checks++;
      if (n_done != 4 || n_perr != nbad || n_soft != 0) begin
         errors++;
         $display("FAIL random_done: got done=%0d perr=%0d soft=%0d required 4/%0d/0",
                  n_done, n_perr, n_soft, nbad);
      end
      checks++;
      if (viol_hold != 0 || viol_occ != 0 || viol_empty != 0) begin
         errors++;
         $display("FAIL random_rules: got hold=%0d occ=%0d empty=%0d required 0/0/0",
                  viol_hold, viol_occ, viol_empty);
      end
   endtask

   task automatic test_timeout();
      int d;
      clear_sb();
      add_pkt({6'd20, 2'd3}, 1'b0);
      for (int i = 0; i < 45; i++) step(1'b0);
      exp_err_total += 1;
      checks++;
      if (n_soft != 1 || soft_bad != 0) begin
         errors++;
         $display("FAIL timeout_pulse: got pulses=%0d misplaced=%0d required 1/0",
                  n_soft, soft_bad);
      end
      checks++;
      if (after_soft_bad != 0) begin
         errors++;
         $display("FAIL timeout_flush: got %0d valid after pulse required 0", after_soft_bad);
      end
      checks++;
      if (n_done != 0 || n_perr != 0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL timeout_abort: got done=%0d perr=%0d bytes=%0d required 0/0/0",
                  n_done, n_perr, obs_q.size());
      end
      clear_sb();
      add_pkt(rand_hdr(10), 1'b0);
      run(100, 0);
      exp_pkt_total += 1;
      d = first_diff();
      checks++;
      if (obs_q.size() != exp_q.size() || d != -1 || n_done != 1) begin
         errors++;
         $display("FAIL timeout_resume: got %0d bytes done=%0d diff=%0d required %0d/1/-1",
                  obs_q.size(), n_done, d, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int d;
`ifdef ROUTER_RD_STATS_EN
      checks++;
      if (pkt_cnt !== 16'(exp_pkt_total) || err_cnt !== 8'(exp_err_total)) begin
         errors++;
         $display("FAIL stats_totals: got %0d/%0d required %0d/%0d",
                  pkt_cnt, err_cnt, exp_pkt_total, exp_err_total);
      end
`endif
      clear_sb();
      add_pkt({6'd40, 2'd1}, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      checks++;
      if ({fifo_rd_en, valid_out, data_out, sop, eop, pkt_done, parity_err, soft_rst_out}
          !== 15'h0) begin
         errors++;
         $display("FAIL midreset_outputs: got %b required 0",
                  {fifo_rd_en, valid_out, data_out, sop, eop, pkt_done, parity_err, soft_rst_out});
      end
`ifdef ROUTER_RD_STATS_EN
      checks++;
      if ({pkt_cnt, err_cnt} !== 24'h0) begin
         errors++;
         $display("FAIL midreset_stats: got %0d/%0d required 0/0", pkt_cnt, err_cnt);
      end
`endif
      fifo_q.delete();
      occ        = 0;
      stall_run  = 0;
      prev_stall = 1'b0;
      prev_soft  = 1'b0;
      fifo_empty = 1'b1;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      clear_sb();
      add_pkt(rand_hdr(63), 1'b0);
      run(200, 0);
      d = first_diff();
      checks++;
      if (obs_q.size() != exp_q.size() || d != -1 || n_done != 1 || n_perr != 0) begin
         errors++;
         $display("FAIL midreset_fresh: got %0d bytes done=%0d perr=%0d required %0d/1/0",
                  obs_q.size(), n_done, n_perr, exp_q.size());
      end
`ifdef ROUTER_RD_STATS_EN
      checks++;
      if (pkt_cnt !== 16'd1 || err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL stats_after_reset: got %0d/%0d required 1/0", pkt_cnt, err_cnt);
      end
`endif
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_pkt();
      test_parity_err();
      test_len0_back_to_back();
      test_toggle();
      test_random_ready();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
